// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and word type used by the A/D registers.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 15;

    typedef logic [DATA_W-1:0] word_t;

    localparam word_t WORD_ZERO = '0;

endpackage : cpu_pkg

// File: rtl/reg16_if.sv
// Data/enable bundle for reg16; out_par exists only when REG16_PARITY_EN is defined.
interface reg16_if
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) ();

    logic [WIDTH-1:0] in;
    logic             load;
    logic [WIDTH-1:0] out;
`ifdef REG16_PARITY_EN
    logic             out_par;
`endif

`ifdef REG16_PARITY_EN
    modport master (output in, output load, input out, input out_par);
    modport slave  (input in, input load, output out, output out_par);
`else
    modport master (output in, output load, input out);
    modport slave  (input in, input load, output out);
`endif

endinterface : reg16_if

// File: rtl/reg16_bit_cell.sv
// Single-bit loadable flop with asynchronous active-low reset to a per-cell value.
module bit_cell (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic load,
    input  logic rst_val,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= rst_val;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : bit_cell

// File: rtl/reg16.sv
// Loadable data register (CPU A/D registers) built from bit_cell flops.
// Optional REG16_PARITY_EN adds a registered even-parity bit out_par.
module reg16
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH       = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(WORD_ZERO)
) (
    input  logic    clk,
    input  logic    rst,
    reg16_if.slave  bus
);

    logic [WIDTH-1:0] q_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        bit_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .d       (bus.in[i]),
            .load    (bus.load),
            .rst_val (RESET_VALUE[i]),
            .q       (q_w[i])
        );
    end

    assign bus.out = q_w;

`ifdef REG16_PARITY_EN
    logic par_q;

    // Parity is captured from in alongside the data, never derived from out.
    bit_cell u_par (
        .clk     (clk),
        .rst     (rst),
        .d       (^bus.in),
        .load    (bus.load),
        .rst_val (^RESET_VALUE),
        .q       (par_q)
    );

    assign bus.out_par = par_q;
`endif

endmodule : reg16

// File: tb/tb_reg16.sv
// Directed self-checking bench for reg16; parity checks build with REG16_PARITY_EN.
module tb_reg16;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    reg16_if #(.WIDTH(16)) bus ();

    reg16 #(
        .WIDTH       (16),
        .RESET_VALUE (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst      = 1'b1;
        bus.in   = 16'hBEEF;
        bus.load = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (bus.out !== 16'h0000)
            $display("FAIL reset_immediate: out=%h expected=%h", bus.out, 16'h0000);
        else
            passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.out !== 16'h0000)
                $display("FAIL reset_hold_%0d: out=%h expected=%h", i, bus.out, 16'h0000);
            else
                passed++;
        end
    endtask

    task automatic test_load();
        @(negedge clk);
        rst      = 1'b1;
        bus.in   = 16'h1234;
        bus.load = 1'b1;
        #1;
        total++;
        if (bus.out !== 16'h0000)
            $display("FAIL load_before_edge: out=%h expected=%h", bus.out, 16'h0000);
        else
            passed++;
        @(posedge clk);
        #1;
        total++;
        if (bus.out !== 16'h1234)
            $display("FAIL load_after_edge: out=%h expected=%h", bus.out, 16'h1234);
        else
            passed++;
    endtask

    task automatic test_hold();
        logic [15:0] vals [4];
        vals[0] = 16'hFFFF;
        vals[1] = 16'h8000;
        vals[2] = 16'h0001;
        vals[3] = 16'hxxxx;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.load = 1'b0;
            bus.in   = vals[i];
            @(posedge clk);
            #1;
            total++;
            if (bus.out !== 16'h1234)
                $display("FAIL hold_%0d: out=%h expected=%h", i, bus.out, 16'h1234);
            else
                passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [3];
        logic [15:0] o;
        vals[0] = 16'h8000;
        vals[1] = 16'h7FFF;
        vals[2] = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.load = 1'b1;
            bus.in   = vals[i];
            #1;
            if (i > 0) begin
                total++;
                if (bus.out !== vals[i-1])
                    $display("FAIL b2b_old_%0d: out=%h expected=%h", i, bus.out, vals[i-1]);
                else
                    passed++;
            end
            @(posedge clk);
            #1;
            total++;
            if (bus.out !== vals[i])
                $display("FAIL b2b_%0d: out=%h expected=%h", i, bus.out, vals[i]);
            else
                passed++;
            if (i == 0) begin
                o = bus.out;
                total++;
                if (o[15] !== 1'b1)
                    $display("FAIL b2b_bit15: bit15=%b expected=1", o[15]);
                else
                    passed++;
            end
        end
    endtask

    task automatic test_reset_during_activity();
        @(negedge clk);
        bus.load = 1'b1;
        bus.in   = 16'h0042;
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (bus.out !== 16'h0000)
            $display("FAIL midreset_immediate: out=%h expected=%h", bus.out, 16'h0000);
        else
            passed++;
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (bus.out !== 16'h0000)
            $display("FAIL midreset_released: out=%h expected=%h", bus.out, 16'h0000);
        else
            passed++;
        @(posedge clk);
        #1;
        total++;
        if (bus.out !== 16'h0042)
            $display("FAIL midreset_reload: out=%h expected=%h", bus.out, 16'h0042);
        else
            passed++;
    endtask

`ifdef REG16_PARITY_EN
    task automatic test_parity();
        @(negedge clk);
        bus.load = 1'b1;
        bus.in   = 16'h0001;
        @(posedge clk);
        #1;
        total++;
        if (bus.out_par !== 1'b1)
            $display("FAIL parity_0001: out_par=%b expected=1", bus.out_par);
        else
            passed++;
        @(negedge clk);
        bus.in = 16'h0003;
        @(posedge clk);
        #1;
        total++;
        if (bus.out_par !== 1'b0)
            $display("FAIL parity_0003: out_par=%b expected=0", bus.out_par);
        else
            passed++;
        @(negedge clk);
        bus.in = 16'h0001;
        rst    = 1'b0;
        #1;
        total++;
        if (bus.out_par !== 1'b0)
            $display("FAIL parity_reset: out_par=%b expected=0", bus.out_par);
        else
            passed++;
        #1;
        rst = 1'b1;
    endtask
`endif

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_load();
        test_hold();
        test_back_to_back();
        test_reset_during_activity();
`ifdef REG16_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_reg16
